shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine.sv | 107 ++++++++++
 tb/tb_shift_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// Multi-cycle shifter: captures an operand, then shifts/rotates it up to STEP
// bit positions per clock until the requested amount is consumed.
module shift_engine #(
  parameter int WIDTH = 5,
  parameter int AW    = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lost,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  state_t           state;
  logic [AW-1:0]    rem;
  logic [2:0]       md;
  logic [WIDTH-1:0] sh_res;
  logic             sh_lost;
  logic [AW-1:0]    rem_nx;

  // One edge's worth of work: min(STEP, rem) single-bit steps, unrolled.
  always_comb begin
    sh_res  = result;
    sh_lost = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem)) begin
        case (md)
          M_SLL: begin sh_lost = sh_lost | sh_res[WIDTH-1]; sh_res = {sh_res[WIDTH-2:0], 1'b0}; end
          M_SRL: begin sh_lost = sh_lost | sh_res[0]; sh_res = {1'b0, sh_res[WIDTH-1:1]}; end
          M_SRA: begin sh_lost = sh_lost | sh_res[0]; sh_res = {sh_res[WIDTH-1], sh_res[WIDTH-1:1]}; end
          M_ROL: sh_res = {sh_res[WIDTH-2:0], sh_res[WIDTH-1]};
          M_ROR: sh_res = {sh_res[0], sh_res[WIDTH-1:1]};
          default: sh_res = sh_res;
        endcase
      end
    end
    // STEP may exceed what AW can count; that case always drains rem in one edge.
    rem_nx = (int'(rem) > STEP) ? rem - AW'(STEP) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      result <= '0;
      rem    <= '0;
      md     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lost   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            result <= data;
            rem    <= amount;
            md     <= mode;
            lost   <= 1'b0;
            err    <= (mode > M_ROR);
            busy   <= 1'b1;
            if (mode > M_ROR || amount == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          result <= sh_res;
          lost   <= lost | sh_lost;
          rem    <= rem_nx;
          if (rem_nx == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Bench for shift_engine: directed cases plus random ops on a STEP=1 and a
// STEP=2 instance, checked against an arithmetic reference model.
module tb_shift_engine;
  localparam int W  = 5;
  localparam int AW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [2:0]   mode;
  logic [W-1:0] data;
  logic [AW-1:0] amount;
  logic         busy0, done0, lost0, err0;
  logic         busy1, done1, lost1, err1;
  logic [W-1:0] result0, result1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_engine #(.WIDTH(W), .AW(AW), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode), .data(data), .amount(amount),
    .busy(busy0), .done(done0), .result(result0), .lost(lost0), .err(err0));

  shift_engine #(.WIDTH(W), .AW(AW), .STEP(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .data(data), .amount(amount),
    .busy(busy1), .done(done1), .result(result1), .lost(lost1), .err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);   return sel != 0 ? busy1 : busy0;     endfunction
  function automatic logic done_of(input int sel);   return sel != 0 ? done1 : done0;     endfunction
  function automatic logic lost_of(input int sel);   return sel != 0 ? lost1 : lost0;     endfunction
  function automatic logic err_of(input int sel);    return sel != 0 ? err1  : err0;      endfunction
  function automatic int   result_of(input int sel); return int'(sel != 0 ? result1 : result0); endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start1 = v; else start0 = v;
  endtask

  // Reference: whole-operation result from arithmetic, not per-edge stepping.
  function automatic void model(input int m, input int d, input int a, input int step,
                                output int res, output int lo, output int er, output int lat);
    int mask, e, r, sx;
    mask = (1 << W) - 1;
    e    = (a < W) ? a : W;
    r    = a % W;
    er   = 0;
    lo   = 0;
    case (m)
      0: begin res = (d << e) & mask; lo = ((d >> (W - e)) != 0) ? 1 : 0; end
      1: begin res = d >> e; lo = ((d & ((1 << e) - 1)) != 0) ? 1 : 0; end
      2: begin
        sx  = ((d >> (W - 1)) & 1) != 0 ? (d | ~mask) : d;
        res = (sx >>> e) & mask;
        lo  = ((d & ((1 << e) - 1)) != 0) ? 1 : 0;
      end
      3: res = ((d << r) | (d >> (W - r))) & mask;
      4: res = ((d >> r) | (d << (W - r))) & mask;
      default: begin res = d; er = 1; end
    endcase
    lat = (er != 0 || a == 0) ? 0 : (a + step - 1) / step;
  endfunction

  // Issue one op, wait for done, check latency/outputs, then check the idle hold.
  task automatic run_op(input int sel, input int m, input int d, input int a,
                        input bit poke, input string tag);
    int  eres, elo, eer, lat, cyc;
    bit  busy_ok;
    model(m, d, a, (sel != 0) ? 2 : 1, eres, elo, eer, lat);
    @(negedge clk);
    mode = 3'(m); data = W'(d); amount = AW'(a);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    cyc = 0; busy_ok = 1'b1;
    while (1) begin
      if (!busy_of(sel)) busy_ok = 1'b0;
      if (done_of(sel)) break;
      if (cyc > 40) break;
      if (poke && cyc == 0) begin
        set_start(sel, 1'b1);
        data = W'(~d); mode = 3'((m + 1) % 5); amount = AW'(a + 1);
      end
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".busy"}, busy_ok, 1);
    chk({tag, ".result"}, result_of(sel), eres);
    chk({tag, ".lost"}, lost_of(sel), elo);
    chk({tag, ".err"}, err_of(sel), eer);
    data = W'($urandom);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done_of(sel), 0);
    chk({tag, ".idle_busy"}, busy_of(sel), 0);
    @(posedge clk); #1;
    chk({tag, ".hold_result"}, result_of(sel), eres);
    chk({tag, ".hold_lost"}, lost_of(sel), elo);
  endtask

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mode = '0; data = '0; amount = '0;
    #2;
    chk("rst.busy", busy0, 0);
    chk("rst.done", done0, 0);
    chk("rst.result", result0, 0);
    chk("rst.lost", lost0, 0);
    chk("rst.err", err0, 0);
    chk("rst.busy1", busy1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    run_op(0, 0, 5'b00011, 2, 1'b0, "sll_basic");
    run_op(0, 2, 5'b10110, 3, 1'b0, "sra_lost");
    run_op(0, 3, 5'b10001, 7, 1'b0, "rol_wrap");
    run_op(0, 1, 5'b10101, 0, 1'b0, "srl_zero");
    run_op(0, 6, 5'b01101, 5, 1'b0, "illegal");
    run_op(0, 3, 5'b11010, 4, 1'b1, "start_ignored");
    run_op(1, 0, 5'b00001, 5, 1'b0, "step2_sll");
    run_op(1, 4, 5'b10011, 7, 1'b1, "step2_ror");
    run_op(0, 2, 5'b10000, 7, 1'b0, "sra_full");
    run_op(0, 1, 5'b11111, 6, 1'b0, "srl_full");

    // Abort mid-RUN: outputs clear without waiting for a clock edge.
    @(negedge clk);
    mode = 3'd0; data = 5'b11111; amount = 3'd6;
    start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort.busy", busy0, 0);
    chk("abort.done", done0, 0);
    chk("abort.result", result0, 0);
    chk("abort.lost", lost0, 0);
    chk("abort.err", err0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort.no_done", done0, 0);
    end
    @(negedge clk); rst = 1'b1;
    run_op(0, 0, 5'b00111, 3, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      run_op(i % 2, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
